// File: rtl/shift_pattern_decoder.sv
// Receive-side decoder for the 5-stage ring/Johnson counter pattern bus.
// Decodes each sample to a step index, tracks sequence lock and counts violations.
module shift_pattern_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_mode,
    input  logic       in_valid,
    input  logic [4:0] pattern,
    input  logic       clr,
    output logic [3:0] step,
    output logic       step_valid,
    output logic       locked,
    output logic       seq_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t     state_reg, state_next;
    logic [3:0] ref_reg, ref_next;
    logic       mode_reg;
    logic       mode_change;

    logic       legal;
    logic [3:0] idx;
    logic [3:0] succ;

    logic [3:0] step_next;
    logic       step_valid_next;
    logic       seq_err_next;
    logic       locked_next;
    logic [7:0] err_count_next;

    assign mode_change = (sw_mode != mode_reg);

    // Pattern decode uses the registered mode; it only differs from sw_mode in
    // a switch cycle, where the sample is discarded anyway.
    always_comb begin
        legal = 1'b0;
        idx   = 4'd0;
        if (mode_reg) begin
            case (pattern)
                5'b00000: begin legal = 1'b1; idx = 4'd0; end
                5'b00001: begin legal = 1'b1; idx = 4'd1; end
                5'b00011: begin legal = 1'b1; idx = 4'd2; end
                5'b00111: begin legal = 1'b1; idx = 4'd3; end
                5'b01111: begin legal = 1'b1; idx = 4'd4; end
                5'b11111: begin legal = 1'b1; idx = 4'd5; end
                5'b11110: begin legal = 1'b1; idx = 4'd6; end
                5'b11100: begin legal = 1'b1; idx = 4'd7; end
                5'b11000: begin legal = 1'b1; idx = 4'd8; end
                5'b10000: begin legal = 1'b1; idx = 4'd9; end
                default:  begin legal = 1'b0; idx = 4'd0; end
            endcase
        end else begin
            case (pattern)
                5'b00001: begin legal = 1'b1; idx = 4'd0; end
                5'b00010: begin legal = 1'b1; idx = 4'd1; end
                5'b00100: begin legal = 1'b1; idx = 4'd2; end
                5'b01000: begin legal = 1'b1; idx = 4'd3; end
                5'b10000: begin legal = 1'b1; idx = 4'd4; end
                default:  begin legal = 1'b0; idx = 4'd0; end
            endcase
        end
    end

    always_comb begin
        if (mode_reg) begin
            succ = (ref_reg == 4'd9) ? 4'd0 : ref_reg + 4'd1;
        end else begin
            succ = (ref_reg == 4'd4) ? 4'd0 : ref_reg + 4'd1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ref_next        = ref_reg;
        step_next       = step;
        step_valid_next = 1'b0;
        seq_err_next    = 1'b0;

        if (mode_change) begin
            state_next = IDLE;
            ref_next   = 4'd0;
        end else if (in_valid) begin
            if (!legal) begin
                seq_err_next = (state_reg == LOCKED);
                state_next   = IDLE;
            end else begin
                step_valid_next = 1'b1;
                step_next       = idx;
                case (state_reg)
                    IDLE: begin
                        ref_next   = idx;
                        state_next = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (idx != ref_reg) begin
                            ref_next = idx;
                            if (idx == succ) begin
                                state_next = LOCKED;
                            end
                        end
                    end
                    LOCKED: begin
                        // A jump to any other legal index re-acquires from it.
                        if (idx != ref_reg) begin
                            ref_next = idx;
                            if (idx != succ) begin
                                seq_err_next = 1'b1;
                                state_next   = ACQUIRE;
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end

        locked_next = (state_next == LOCKED);

        if (clr) begin
            err_count_next = 8'd0;
        end else if (seq_err_next && (err_count != 8'hFF)) begin
            err_count_next = err_count + 8'd1;
        end else begin
            err_count_next = err_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ref_reg    <= 4'd0;
            mode_reg   <= 1'b0;
            step       <= 4'd0;
            step_valid <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            state_reg  <= state_next;
            ref_reg    <= ref_next;
            mode_reg   <= sw_mode;
            step       <= step_next;
            step_valid <= step_valid_next;
            locked     <= locked_next;
            seq_err    <= seq_err_next;
            err_count  <= err_count_next;
        end
    end

endmodule

// File: doc/shift_pattern_decoder.md
# shift_pattern_decoder

Decodes the 5-bit pattern produced by the team's D-flip-flop ring/Johnson counter back into a step index and checks that successive samples follow the legal shift sequence. It sits on the receive side of the counter's 5-bit LED/pattern bus. It reports decoded step, lock status, per-sample sequence errors and a saturating error count. Every output is registered.

## Interface

Parameters:
- none. Widths are fixed by the 5-stage counter.

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  reset, asynchronous and active-low
- sw_mode  input  1  1 = Johnson sequence, 0 = ring (one-hot) sequence
- in_valid  input  1  pattern is sampled on a posedge where in_valid = 1
- pattern  input  5  counter state Q[4:0]
- clr  input  1  synchronous clear of err_count
- step  output  4  decoded index of the last legal sample
- step_valid  output  1  one-cycle pulse when a legal sample is decoded
- locked  output  1  high while the decoder is in LOCKED
- seq_err  output  1  one-cycle pulse on a sequence violation while LOCKED
- err_count  output  8  saturating count of seq_err events

## Operation

- Counter shift rule, which defines the successor pattern:
  - Q[i] takes Q[i-1] for i = 1..4.
  - Ring mode: Q[0] takes Q[4].
  - Johnson mode: Q[0] takes ~Q[4].
- Ring decode:
  - Legal patterns are exactly one bit set.
  - step = position of that bit, 0..4.
  - Successor of index i is (i+1) mod 5.
- Johnson decode, index 0..9 in order: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
  - Any other pattern is illegal.
  - Successor of index i is (i+1) mod 10.
- A reference register holds the index of the last accepted legal sample.
- A sample whose index equals the reference is a hold. It is not an error and does not advance.
- FSM states: IDLE, ACQUIRE, LOCKED.
  - IDLE, legal sample: store reference, go to ACQUIRE.
  - IDLE, illegal sample: stay in IDLE.
  - ACQUIRE, successor: update reference, go to LOCKED.
  - ACQUIRE, hold: stay in ACQUIRE.
  - ACQUIRE, other legal sample: becomes the new reference, stay in ACQUIRE.
  - ACQUIRE, illegal sample: go to IDLE.
  - LOCKED, successor: update reference, stay in LOCKED.
  - LOCKED, hold: stay in LOCKED.
  - LOCKED, legal non-successor: seq_err, new reference, go to ACQUIRE.
  - LOCKED, illegal sample: seq_err, go to IDLE.
- seq_err is generated only from LOCKED.
- err_count:
  - Increments on each seq_err.
  - Saturates at 255.
  - clr sets it to 0. clr has priority over a simultaneous increment; seq_err still pulses in that cycle.
- step_valid pulses for every legal sample, including holds. step is updated at the same time and otherwise holds its value.
- Cycles with in_valid = 0 change nothing except the clr effect on err_count.
- A sw_mode change, detected by comparing against a registered copy:
  - forces IDLE on the next posedge and clears the reference;
  - produces no seq_err;
  - ignores any sample in that cycle.

## Timing

- Reset (rst_n = 0, asynchronous):
  - step = 0, step_valid = 0, locked = 0, seq_err = 0, err_count = 0;
  - FSM = IDLE, reference = 0, registered sw_mode = 0.
- Latency: 1 cycle. A sample taken at edge N drives step, step_valid, seq_err and locked after edge N.
- step_valid and seq_err are single-cycle pulses. Back-to-back samples produce back-to-back pulses.
- Deassertion of rst_n mid-sequence restarts from IDLE. At least two legal consecutive samples are required to reach locked = 1.
- No backpressure: a sample is accepted on every in_valid cycle.

## Test plan

- Johnson walk: sw_mode = 1, feed 00000, 00001, 00011 with in_valid each cycle.
  - Required: step = 0, 1, 2 with step_valid pulses.
  - Required: locked = 1 after the second sample; err_count stays 0.
- Wrap: ring mode, feed 10000 then 00001.
  - Required: step 4 then 0, locked = 1, no seq_err.
  - Johnson 10000 then 00000 behaves the same way: step 9 then 0, locked = 1.
- Violation: Johnson locked at 00011, feed 01111 (skip).
  - Required: seq_err pulse, err_count = 1, locked = 0, step = 4.
  - Then feed 11111: locked = 1 again.
- Illegal pattern: ring locked, feed 00110.
  - Required: seq_err pulse, step_valid = 0, IDLE.
  - Feed 00110 again: no seq_err, err_count unchanged.
- Saturation and clear:
  - Force 260 violations: err_count = 255.
  - clr together with a violation: err_count = 0 and seq_err = 1.
- Mode switch and reset: while locked, toggle sw_mode.
  - Required: locked = 0, no seq_err.
  - Assert rst_n low mid-stream: all outputs 0 immediately, without waiting for a clock edge.
